axi_pkt_gate: RTL and testbench

//  Packet-admission stage directly upstream of the AXI FIFO (s_axis side).

---
 rtl/axi_pkt_gate.sv | 184 ++++++++++++++++++
 tb/tb_axi_pkt_gate.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_pkt_gate.sv
// Packet admission gate in front of an AXI-Stream FIFO: drops whole packets when the FIFO is
// almost full at the head beat, truncates overlong packets, and registers the output through a skid buffer.
module axi_pkt_gate #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PKT_LEN = 256,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  fifo_almost_full,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [CNT_WIDTH-1:0]  trunc_cnt
);

    localparam int BW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(MAX_PKT_LEN - 1);

    typedef enum logic [1:0] {
        START,
        PASS,
        DROP,
        TRUNC
    } state_t;

    state_t state_reg, state_next;

    logic [BW-1:0]         beat_cnt_reg, beat_cnt_next, beat_idx;
    logic                  s_ready_reg, s_ready_next;

    logic                  main_valid_reg, main_valid_next;
    logic [DATA_WIDTH-1:0] main_data_reg, main_data_next;
    logic                  main_last_reg, main_last_next;
    logic                  skid_valid_reg, skid_valid_next;
    logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
    logic                  skid_last_reg, skid_last_next;

    logic                  accept;
    logic                  fwd;
    logic                  fwd_last;
    logic                  pop;
    logic [1:0]            cnt_inc;

    assign accept   = s_axis_tvalid & s_ready_reg;
    assign pop      = main_valid_reg & m_axis_tready;
    assign beat_idx = (state_reg == START) ? '0 : beat_cnt_reg;

    // Packet-level decisions: admit/drop at the head, truncate at the length limit.
    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        fwd           = 1'b0;
        fwd_last      = s_axis_tlast;
        cnt_inc       = 2'b00;

        if (accept) begin
            case (state_reg)
                START: begin
                    if (fifo_almost_full) begin
                        cnt_inc[0] = 1'b1;
                        state_next = s_axis_tlast ? START : DROP;
                    end else begin
                        fwd = 1'b1;
                    end
                end
                PASS: fwd = 1'b1;
                DROP, TRUNC: begin
                    if (s_axis_tlast) begin
                        state_next = START;
                    end
                end
                default: state_next = START;
            endcase
        end

        if (fwd) begin
            if ((beat_idx == LAST_IDX) && !s_axis_tlast) begin
                fwd_last      = 1'b1;
                cnt_inc[1]    = 1'b1;
                state_next    = TRUNC;
                beat_cnt_next = '0;
            end else if (s_axis_tlast) begin
                state_next    = START;
                beat_cnt_next = '0;
            end else begin
                state_next    = PASS;
                beat_cnt_next = beat_idx + 1'b1;
            end
        end
    end

    // Two-entry output buffer: the skid entry absorbs the beat accepted while the output stalls,
    // which lets the input ready be a pure register.
    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        main_last_next  = main_last_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_last_next  = skid_last_reg;

        if (pop) begin
            if (skid_valid_reg) begin
                main_data_next  = skid_data_reg;
                main_last_next  = skid_last_reg;
                skid_valid_next = 1'b0;
            end else begin
                main_valid_next = 1'b0;
            end
        end

        if (fwd) begin
            if (!main_valid_next) begin
                main_valid_next = 1'b1;
                main_data_next  = s_axis_tdata;
                main_last_next  = fwd_last;
            end else if (!skid_valid_next) begin
                skid_valid_next = 1'b1;
                skid_data_next  = s_axis_tdata;
                skid_last_next  = fwd_last;
            end
        end

        if ((state_next == DROP) || (state_next == TRUNC)) begin
            s_ready_next = 1'b1;
        end else begin
            s_ready_next = ~skid_valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_reg      <= START;
            beat_cnt_reg   <= '0;
            s_ready_reg    <= 1'b1;
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_last_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_last_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beat_cnt_reg   <= beat_cnt_next;
            s_ready_reg    <= s_ready_next;
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            main_last_reg  <= main_last_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_last_reg  <= skid_last_next;
        end
    end

    // Index 0 counts dropped packets, index 1 counts truncated packets; both hold at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sat
            logic [CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (sync_reset) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign drop_cnt      = g_sat[0].cnt_reg;
    assign trunc_cnt     = g_sat[1].cnt_reg;
    assign s_axis_tready = s_ready_reg;
    assign m_axis_tvalid = main_valid_reg;
    assign m_axis_tdata  = main_data_reg;
    assign m_axis_tlast  = main_last_reg;

endmodule

// File: tb/tb_axi_pkt_gate.sv
// Directed bench for axi_pkt_gate with MAX_PKT_LEN=4 and CNT_WIDTH=3: a vector table for
// streaming/drop/truncate/backpressure plus hand-written reset and saturation sequences.
module tb_axi_pkt_gate;

    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          fifo_almost_full;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] trunc_cnt;

    int checks   = 0;
    int failures = 0;

    axi_pkt_gate #(
        .DATA_WIDTH (DW),
        .MAX_PKT_LEN(4),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .sync_reset      (sync_reset),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .fifo_almost_full(fifo_almost_full),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .drop_cnt        (drop_cnt),
        .trunc_cnt       (trunc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        af;
        logic        mr;
        logic        emv;
        logic [31:0] emd;
        logic        eml;
        logic        esr;
        int          edrop;
        int          etrunc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [31:0] d, input logic l, input logic af,
                       input logic mr, input logic emv, input logic [31:0] emd, input logic eml,
                       input logic esr, input int edrop, input int etrunc);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.af = af; t.mr = mr;
        t.emv = emv; t.emd = emd; t.eml = eml; t.esr = esr;
        t.edrop = edrop; t.etrunc = etrunc;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic af,
                        input logic mr);
        s_axis_tvalid    = v;
        s_axis_tdata     = d;
        s_axis_tlast     = l;
        fifo_almost_full = af;
        m_axis_tready    = mr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1: plain 4-beat packet
        add(1, 32'h01, 0, 0, 1,  1, 32'h01, 0, 1, 0, 0);
        add(1, 32'h02, 0, 0, 1,  1, 32'h02, 0, 1, 0, 0);
        add(1, 32'h03, 0, 0, 1,  1, 32'h03, 0, 1, 0, 0);
        add(1, 32'h04, 1, 0, 1,  1, 32'h04, 1, 1, 0, 0);
        add(0, 32'h00, 0, 0, 1,  0, 32'h00, 0, 1, 0, 0);
        // Test 2: head sees almost_full, whole packet dropped, next passes
        add(1, 32'h10, 0, 1, 1,  0, 32'h00, 0, 1, 1, 0);
        add(1, 32'h11, 0, 0, 1,  0, 32'h00, 0, 1, 1, 0);
        add(1, 32'h12, 1, 0, 1,  0, 32'h00, 0, 1, 1, 0);
        add(1, 32'h20, 1, 0, 1,  1, 32'h20, 1, 1, 1, 0);
        add(0, 32'h00, 0, 0, 1,  0, 32'h00, 0, 1, 1, 0);
        // Test 3: 6-beat packet truncated at 4, then exact 4-beat packet
        add(1, 32'h31, 0, 0, 1,  1, 32'h31, 0, 1, 1, 0);
        add(1, 32'h32, 0, 0, 1,  1, 32'h32, 0, 1, 1, 0);
        add(1, 32'h33, 0, 0, 1,  1, 32'h33, 0, 1, 1, 0);
        add(1, 32'h34, 0, 0, 1,  1, 32'h34, 1, 1, 1, 1);
        add(1, 32'h35, 0, 0, 1,  0, 32'h00, 0, 1, 1, 1);
        add(1, 32'h36, 1, 0, 1,  0, 32'h00, 0, 1, 1, 1);
        add(1, 32'h41, 0, 0, 1,  1, 32'h41, 0, 1, 1, 1);
        add(1, 32'h42, 0, 0, 1,  1, 32'h42, 0, 1, 1, 1);
        add(1, 32'h43, 0, 0, 1,  1, 32'h43, 0, 1, 1, 1);
        add(1, 32'h44, 1, 0, 1,  1, 32'h44, 1, 1, 1, 1);
        add(0, 32'h00, 0, 0, 1,  0, 32'h00, 0, 1, 1, 1);
        // Test 4: output ready pattern 1,0,0,1 across two 4-beat packets
        add(1, 32'h51, 0, 0, 1,  1, 32'h51, 0, 1, 1, 1);
        add(1, 32'h52, 0, 0, 0,  1, 32'h51, 0, 0, 1, 1);
        add(1, 32'h53, 0, 0, 0,  1, 32'h51, 0, 0, 1, 1);
        add(1, 32'h53, 0, 0, 1,  1, 32'h52, 0, 1, 1, 1);
        add(1, 32'h53, 0, 0, 1,  1, 32'h53, 0, 1, 1, 1);
        add(1, 32'h54, 1, 0, 0,  1, 32'h53, 0, 0, 1, 1);
        add(1, 32'h55, 0, 0, 0,  1, 32'h53, 0, 0, 1, 1);
        add(1, 32'h55, 0, 0, 1,  1, 32'h54, 1, 1, 1, 1);
        add(1, 32'h55, 0, 0, 1,  1, 32'h55, 0, 1, 1, 1);
        add(1, 32'h56, 0, 0, 0,  1, 32'h55, 0, 0, 1, 1);
        add(1, 32'h57, 0, 0, 0,  1, 32'h55, 0, 0, 1, 1);
        add(1, 32'h57, 0, 0, 1,  1, 32'h56, 0, 1, 1, 1);
        add(1, 32'h57, 0, 0, 1,  1, 32'h57, 0, 1, 1, 1);
        add(1, 32'h58, 1, 0, 0,  1, 32'h57, 0, 0, 1, 1);
        add(0, 32'h00, 0, 0, 0,  1, 32'h57, 0, 0, 1, 1);
        add(0, 32'h00, 0, 0, 1,  1, 32'h58, 1, 1, 1, 1);
        add(0, 32'h00, 0, 0, 1,  0, 32'h00, 0, 1, 1, 1);

        sync_reset = 1'b1;
        step(0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 1);
        sync_reset = 1'b0;
        check("rst_tvalid", int'(m_axis_tvalid), 0);
        check("rst_tdata", int'(m_axis_tdata), 0);
        check("rst_tlast", int'(m_axis_tlast), 0);
        check("rst_tready", int'(s_axis_tready), 1);
        check("rst_drop", int'(drop_cnt), 0);
        check("rst_trunc", int'(trunc_cnt), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].af, vecs[i].mr);
            $display("vec %0d: in v=%0b d=%0h l=%0b af=%0b mr=%0b -> out v=%0b d=%0h l=%0b sr=%0b drop=%0d trunc=%0d",
                     i, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].af, vecs[i].mr,
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, drop_cnt, trunc_cnt);
            check($sformatf("vec%0d_tvalid", i), int'(m_axis_tvalid), int'(vecs[i].emv));
            if (vecs[i].emv) begin
                check($sformatf("vec%0d_tdata", i), int'(m_axis_tdata), int'(vecs[i].emd));
                check($sformatf("vec%0d_tlast", i), int'(m_axis_tlast), int'(vecs[i].eml));
            end
            check($sformatf("vec%0d_s_tready", i), int'(s_axis_tready), int'(vecs[i].esr));
            check($sformatf("vec%0d_drop", i), int'(drop_cnt), vecs[i].edrop);
            check($sformatf("vec%0d_trunc", i), int'(trunc_cnt), vecs[i].etrunc);
        end

        // Test 5: reset while a passed packet's head is still held in the output register
        step(1, 32'h61, 0, 0, 0);
        $display("rst5 head: v=%0b d=%0h", m_axis_tvalid, m_axis_tdata);
        check("t5_head_valid", int'(m_axis_tvalid), 1);
        check("t5_head_data", int'(m_axis_tdata), 32'h61);
        sync_reset = 1'b1;
        step(1, 32'h62, 0, 0, 0);
        sync_reset = 1'b0;
        $display("rst5 reset: v=%0b sr=%0b drop=%0d trunc=%0d", m_axis_tvalid, s_axis_tready, drop_cnt, trunc_cnt);
        check("t5_rst_valid", int'(m_axis_tvalid), 0);
        check("t5_rst_tready", int'(s_axis_tready), 1);
        check("t5_rst_drop", int'(drop_cnt), 0);
        check("t5_rst_trunc", int'(trunc_cnt), 0);
        step(1, 32'h63, 0, 1, 1);
        $display("rst5 new head dropped: v=%0b drop=%0d", m_axis_tvalid, drop_cnt);
        check("t5_newhead_valid", int'(m_axis_tvalid), 0);
        check("t5_newhead_drop", int'(drop_cnt), 1);
        step(1, 32'h64, 1, 0, 1);
        $display("rst5 tail discarded: v=%0b", m_axis_tvalid);
        check("t5_tail_valid", int'(m_axis_tvalid), 0);
        step(1, 32'h65, 1, 0, 1);
        $display("rst5 next packet: v=%0b d=%0h l=%0b", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        check("t5_next_valid", int'(m_axis_tvalid), 1);
        check("t5_next_data", int'(m_axis_tdata), 32'h65);
        check("t5_next_last", int'(m_axis_tlast), 1);

        // Test 6: 2^3+3 dropped single-beat packets saturate drop_cnt at 7
        sync_reset = 1'b1;
        step(0, 32'h0, 0, 0, 1);
        sync_reset = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            int exp_drop;
            exp_drop = (k > 7) ? 7 : k;
            step(1, 32'h70 + k, 1, 1, 1);
            $display("sat %0d: drop=%0d v=%0b sr=%0b", k, drop_cnt, m_axis_tvalid, s_axis_tready);
            check($sformatf("t6_drop_%0d", k), int'(drop_cnt), exp_drop);
            check($sformatf("t6_valid_%0d", k), int'(m_axis_tvalid), 0);
            check($sformatf("t6_tready_%0d", k), int'(s_axis_tready), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
